// File: rtl/program_loader.sv
// Boot-time program loader.
// Accepts a framed byte stream (SYNC, LEN, LEN payload bytes, CSUM) over a
// valid/ready handshake, writes the payload into byte-wide instruction memory
// and releases the CPU (CpuRun) only once the 8-bit payload checksum matches.
module program_loader #(
  parameter int unsigned MEM_BYTES = 128,
  parameter int unsigned BASE_ADDR = 0,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic       Clock,
  input  logic       ResetN,
  input  logic [7:0] InData,
  input  logic       InValid,
  output logic       InReady,
  input  logic       Restart,
  output logic       MemWrEn,
  output logic [6:0] MemAddr,
  output logic [7:0] MemWrData,
  output logic       CpuRun,
  output logic       LoadError,
  output logic [7:0] BytesLoaded
);

  // Largest legal LEN; 9 bits so a full 128-byte window still compares cleanly.
  localparam int unsigned MaxLenInt = MEM_BYTES - BASE_ADDR;
  localparam logic [8:0]  MaxLen    = 9'(MaxLenInt);
  localparam logic [6:0]  BaseAddr  = 7'(BASE_ADDR);

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StData,
    StCsum,
    StDone,
    StError
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] len_q, len_d;
  logic [7:0] csum_q, csum_d;
  logic [7:0] count_q, count_d;
  logic       err_q, err_d;
  logic       wr_en_q, wr_en_d;
  logic [6:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;

  logic       accept;
  logic       len_bad;
  logic       last_payload;

  // A byte transfers only when both sides agree at the rising edge.
  assign accept       = InValid & InReady;
  assign len_bad      = (InData == 8'd0) || ({1'b0, InData} > MaxLen);
  assign last_payload = ((count_q + 8'd1) == len_q);

  // Next-state, datapath updates and the registered write strobe.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    csum_d  = csum_q;
    count_d = count_q;
    err_d   = err_q;
    wr_en_d = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    if (Restart) begin
      // Restart wins over a coincident transfer; that byte is dropped.
      // LoadError and BytesLoaded are left for software to inspect.
      state_d = StIdle;
    end else if (accept) begin
      unique case (state_q)
        StIdle: begin
          if (InData == SYNC_BYTE) begin
            state_d = StLen;
            csum_d  = 8'd0;
            count_d = 8'd0;
            err_d   = 1'b0;
          end
        end
        StLen: begin
          if (len_bad) begin
            state_d = StError;
            err_d   = 1'b1;
          end else begin
            len_d   = InData;
            state_d = StData;
          end
        end
        StData: begin
          wr_en_d = 1'b1;
          addr_d  = BaseAddr + count_q[6:0];
          wdata_d = InData;
          csum_d  = csum_q + InData;
          count_d = count_q + 8'd1;
          if (last_payload) begin
            state_d = StCsum;
          end
        end
        StCsum: begin
          if (InData == csum_q) begin
            state_d = StDone;
          end else begin
            state_d = StError;
            err_d   = 1'b1;
          end
        end
        default: begin
          // StDone / StError never accept bytes.
        end
      endcase
    end
  end

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= StIdle;
      len_q   <= 8'd0;
      csum_q  <= 8'd0;
      count_q <= 8'd0;
      err_q   <= 1'b0;
      wr_en_q <= 1'b0;
      addr_q  <= 7'd0;
      wdata_q <= 8'd0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      csum_q  <= csum_d;
      count_q <= count_d;
      err_q   <= err_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Status outputs decoded directly from state so reset takes effect at once.
  always_comb begin
    InReady = 1'b0;
    CpuRun  = 1'b0;
    unique case (state_q)
      StIdle, StLen, StData, StCsum: InReady = 1'b1;
      StDone:                        CpuRun  = 1'b1;
      default: begin
      end
    endcase
  end

  assign MemWrEn     = wr_en_q;
  assign MemAddr     = addr_q;
  assign MemWrData   = wdata_q;
  assign LoadError   = err_q;
  assign BytesLoaded = count_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed testbench for program_loader.
module tb_program_loader;

  logic       Clock;
  logic       ResetN;
  logic [7:0] InData;
  logic       InValid;
  logic       InReady;
  logic       Restart;
  logic       MemWrEn;
  logic [6:0] MemAddr;
  logic [7:0] MemWrData;
  logic       CpuRun;
  logic       LoadError;
  logic [7:0] BytesLoaded;

  int vectors     = 0;
  int miscompares = 0;
  int wr_count    = 0;
  int base;
  logic [7:0] mem [128];

  program_loader #(
    .MEM_BYTES(128),
    .BASE_ADDR(0),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .Clock      (Clock),
    .ResetN     (ResetN),
    .InData     (InData),
    .InValid    (InValid),
    .InReady    (InReady),
    .Restart    (Restart),
    .MemWrEn    (MemWrEn),
    .MemAddr    (MemAddr),
    .MemWrData  (MemWrData),
    .CpuRun     (CpuRun),
    .LoadError  (LoadError),
    .BytesLoaded(BytesLoaded)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Instruction memory model: captures each strobe at the rising edge.
  always @(posedge Clock) begin
    if (MemWrEn === 1'b1) begin
      mem[MemAddr] <= MemWrData;
      wr_count     <= wr_count + 1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    InData  = b;
    InValid = 1'b1;
    @(posedge Clock);
    #1;
    InValid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic pulse_restart();
    Restart = 1'b1;
    @(posedge Clock);
    #1;
    Restart = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, InReady, 1);
    chk({tag, "_wren"},  MemWrEn, 0);
    chk({tag, "_addr"},  MemAddr, 0);
    chk({tag, "_wdata"}, MemWrData, 0);
    chk({tag, "_run"},   CpuRun, 0);
    chk({tag, "_err"},   LoadError, 0);
    chk({tag, "_bytes"}, BytesLoaded, 0);
  endtask

  initial begin
    ResetN  = 1'b0;
    InValid = 1'b0;
    InData  = 8'h00;
    Restart = 1'b0;
    #12;
    chk_reset_vals("reset");
    ResetN = 1'b1;

    // Clean load: A5,04,11,22,33,44,AA
    base = wr_count;
    send(8'hA5);
    chk("clean_ready_len", InReady, 1);
    send(8'h04);
    chk("clean_nowr_len", MemWrEn, 0);
    send(8'h11);
    chk("clean_wr0_en", MemWrEn, 1);
    chk("clean_wr0_addr", MemAddr, 0);
    chk("clean_wr0_data", MemWrData, 8'h11);
    send(8'h22);
    chk("clean_wr1_en", MemWrEn, 1);
    chk("clean_wr1_addr", MemAddr, 1);
    chk("clean_wr1_data", MemWrData, 8'h22);
    send(8'h33);
    chk("clean_wr2_addr", MemAddr, 2);
    chk("clean_wr2_data", MemWrData, 8'h33);
    send(8'h44);
    chk("clean_wr3_en", MemWrEn, 1);
    chk("clean_wr3_addr", MemAddr, 3);
    chk("clean_wr3_data", MemWrData, 8'h44);
    chk("clean_run_early", CpuRun, 0);
    send(8'hAA);
    chk("clean_run", CpuRun, 1);
    chk("clean_wren_off", MemWrEn, 0);
    chk("clean_bytes", BytesLoaded, 4);
    chk("clean_ready", InReady, 0);
    chk("clean_err", LoadError, 0);
    chk("clean_wcount", wr_count - base, 4);
    chk("clean_mem3", mem[3], 8'h44);
    idle(2);
    chk("clean_run_hold", CpuRun, 1);
    pulse_restart();
    chk("restart_run", CpuRun, 0);
    chk("restart_ready", InReady, 1);
    chk("restart_bytes_hold", BytesLoaded, 4);

    // Bad checksum: A5,02,01,02,00
    base = wr_count;
    send(8'hA5);
    send(8'h02);
    send(8'h01);
    send(8'h02);
    send(8'h00);
    chk("badcs_err", LoadError, 1);
    chk("badcs_run", CpuRun, 0);
    chk("badcs_ready", InReady, 0);
    chk("badcs_bytes", BytesLoaded, 2);
    chk("badcs_wcount", wr_count - base, 2);
    pulse_restart();
    chk("badcs_err_hold", LoadError, 1);
    send(8'hA5);
    chk("sync_clears_err", LoadError, 0);
    chk("sync_clears_bytes", BytesLoaded, 0);
    pulse_restart();

    // Length bounds
    send(8'hA5);
    send(8'h00);
    chk("len0_err", LoadError, 1);
    chk("len0_ready", InReady, 0);
    pulse_restart();
    send(8'hA5);
    send(8'h81);
    chk("len129_err", LoadError, 1);
    chk("len129_run", CpuRun, 0);
    pulse_restart();
    base = wr_count;
    send(8'hA5);
    send(8'h80);
    chk("len128_ok", LoadError, 0);
    for (int i = 0; i < 128; i++) begin
      send(8'h01);
      chk("big_wren", MemWrEn, 1);
      chk("big_addr", MemAddr, i);
    end
    chk("big_ready_csum", InReady, 1);
    send(8'h80);
    chk("big_run", CpuRun, 1);
    chk("big_bytes", BytesLoaded, 8'h80);
    chk("big_wcount", wr_count - base, 128);
    chk("big_mem127", mem[127], 8'h01);
    pulse_restart();

    // Garbage before sync, gaps inside the frame
    base = wr_count;
    send(8'h00);
    send(8'hFF);
    chk("garbage_ready", InReady, 1);
    chk("garbage_nowr", wr_count - base, 0);
    send(8'hA5);
    send(8'h01);
    idle(5);
    chk("gap_ready", InReady, 1);
    chk("gap_nowr", MemWrEn, 0);
    send(8'h7E);
    chk("gap_wr_en", MemWrEn, 1);
    chk("gap_wr_addr", MemAddr, 0);
    chk("gap_wr_data", MemWrData, 8'h7E);
    send(8'h7E);
    chk("gap_run", CpuRun, 1);
    chk("gap_wcount", wr_count - base, 1);
    pulse_restart();

    // Restart coincident with a payload byte
    base = wr_count;
    send(8'hA5);
    send(8'h03);
    send(8'h10);
    chk("rs_wr_addr", MemAddr, 0);
    InData  = 8'h20;
    InValid = 1'b1;
    Restart = 1'b1;
    @(posedge Clock);
    #1;
    InValid = 1'b0;
    Restart = 1'b0;
    chk("rs_dropped_wren", MemWrEn, 0);
    chk("rs_ready", InReady, 1);
    send(8'hA5);
    send(8'h01);
    send(8'h55);
    chk("rs_new_addr", MemAddr, 0);
    chk("rs_new_data", MemWrData, 8'h55);
    send(8'h55);
    chk("rs_run", CpuRun, 1);
    chk("rs_wcount", wr_count - base, 2);
    chk("rs_mem1_untouched", mem[1], 8'h01);
    pulse_restart();

    // Asynchronous reset mid-DATA
    send(8'hA5);
    send(8'h03);
    send(8'hC1);
    chk("ar_wr_data", MemWrData, 8'hC1);
    #3;
    ResetN = 1'b0;
    #1;
    chk_reset_vals("areset");
    #1;
    ResetN = 1'b1;
    base = wr_count;
    send(8'hA5);
    send(8'h02);
    send(8'h0F);
    chk("ar_fresh_addr0", MemAddr, 0);
    send(8'hF0);
    chk("ar_fresh_addr1", MemAddr, 1);
    chk("ar_fresh_data1", MemWrData, 8'hF0);
    send(8'hFF);
    chk("ar_fresh_run", CpuRun, 1);
    chk("ar_fresh_bytes", BytesLoaded, 2);
    chk("ar_fresh_wcount", wr_count - base, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time loader sitting directly upstream of the CPU's byte-wide instruction memory (128 x 8, big-endian instruction words).
- Receives a framed byte stream over a valid/ready handshake and writes the payload bytes into instruction memory.
- Verifies an 8-bit checksum, then releases the CPU by asserting CpuRun.
- Holds the CPU stalled (CpuRun=0) until a frame loads cleanly.

Parameters:
MEM_BYTES, 128, instruction memory depth in bytes
BASE_ADDR, 0, first byte address written; payload fills BASE_ADDR upward
SYNC_BYTE, 8'hA5, frame start marker

Ports:
Clock  input  1  system clock, all state updates on rising edge
ResetN  input  1  asynchronous active-low reset
InData  input  8  incoming stream byte
InValid  input  1  InData valid this cycle
InReady  output  1  loader can accept a byte; transfer occurs when InValid & InReady at rising edge
Restart  input  1  synchronous pulse; abandon current state and wait for a new frame
MemWrEn  output  1  instruction memory byte write strobe
MemAddr  output  7  instruction memory byte address
MemWrData  output  8  byte to write
CpuRun  output  1  1 = program loaded and verified; CPU may clock PC/registers
LoadError  output  1  sticky error flag for the last frame
BytesLoaded  output  8  payload bytes written in current/last frame

Behaviour:
- Reset (ResetN=0, asynchronous): state=IDLE; InReady=1; MemWrEn=0; MemAddr=0; MemWrData=0; CpuRun=0; LoadError=0; BytesLoaded=0; internal length=0; checksum=0.
- Frame format: SYNC_BYTE, LEN (1..MEM_BYTES-BASE_ADDR), LEN payload bytes, CSUM. CSUM = 8-bit modulo-256 sum of the payload bytes only.
- States and transitions (all on accepted byte unless noted):
  - IDLE: byte==SYNC_BYTE -> LEN; checksum cleared, BytesLoaded cleared, LoadError cleared. Any other byte is discarded and the state stays IDLE.
  - LEN: LEN==0 or LEN>MEM_BYTES-BASE_ADDR -> ERROR. Otherwise latch LEN -> DATA.
  - DATA: each byte is written and added to the checksum, and BytesLoaded increments. After the LEN-th byte -> CSUM.
  - CSUM: byte==checksum -> DONE. Mismatch -> ERROR.
  - DONE: CpuRun=1, InReady=0. Bytes are not accepted.
  - ERROR: LoadError=1, CpuRun=0, InReady=0.
- InReady = 1 in IDLE, LEN, DATA and CSUM; 0 in DONE and ERROR.
- Write timing: a payload byte accepted at edge k produces MemWrEn=1 during cycle k+1, with MemAddr=BASE_ADDR+index and MemWrData=byte. Memory captures it on edge k+1. MemWrEn is a single-cycle strobe per byte. Back-to-back bytes produce back-to-back strobes.
- Addressing: MemAddr is 7 bits. The length check guarantees no wrap past MEM_BYTES-1; wrap is never produced.
- CpuRun rises on the cycle after the correct CSUM byte is accepted, i.e. one cycle after the final payload write strobe at the earliest. It stays high until Restart or reset.
- Restart=1 at an edge: next state IDLE, CpuRun=0, MemWrEn=0. Restart takes priority over a simultaneous byte transfer; that byte is dropped. LoadError and BytesLoaded hold until the next SYNC is accepted.
- Reset mid-frame: immediate return to reset values; partially written memory is not cleared.
- An error leaves already written bytes in memory; only CpuRun gates execution.
- InValid=0 gaps of any length inside a frame are legal; state is held.

Test Plan:
- Clean load: A5,04,11,22,33,44,AA -> strobes at addr 0..3 with data 11,22,33,44 in consecutive cycles; CpuRun=1 one cycle after AA accepted; BytesLoaded=4; InReady=0.
- Bad checksum: A5,02,01,02,00 -> two writes, LoadError=1, CpuRun=0, InReady=0.
- Length bounds: A5,00 -> ERROR. A5,81 (129) -> ERROR. A5,80 with 128 bytes of value 01 and CSUM 80 -> addr 0..127 written; CpuRun=1; MemAddr never wraps.
- Garbage before sync plus gaps: 00,FF,A5,01 then InValid low for 5 cycles, then 7E,7E -> exactly one write (addr 0, 7E); CpuRun=1.
- Restart with a simultaneous byte mid-DATA, then a new frame A5,01,55,55 -> the byte coinciding with Restart is not written; the new frame writes addr 0=55; CpuRun=1.
- Async reset: assert ResetN=0 between clock edges during DATA -> all outputs reach reset values immediately; CpuRun=0; after release a fresh frame loads normally.
